fb_fill_scheduler: RTL



---
 rtl/screen_pkg.sv | 21 ++
 rtl/fill_cursor.sv | 77 +++++++
 rtl/fb_fill_scheduler.sv | 87 ++++++++
 3 files changed

// File: rtl/screen_pkg.sv
// Shared screen geometry, colour type and fill-engine state encoding for the
// 640x480 24-bit framebuffer path.
package screen_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COLOR_W = 24;
  localparam int ADDR_W  = 19;

  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

  localparam color_t COLOR_BLACK = 24'h000000;
  localparam color_t COLOR_WHITE = 24'hFFFFFF;

endpackage

// File: rtl/fill_cursor.sv
// Raster cursor for one rectangle fill: clips the request to the screen,
// walks columns then rows, and flags the final pixel of the rectangle.
module fill_cursor
  import screen_pkg::*;
(
  input  logic              clk_display,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [9:0]        x0,
  input  logic [8:0]        y0,
  input  logic [9:0]        w,
  input  logic [8:0]        h,
  output logic              empty,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [10:0]       X_LIM    = 11'(H_RES);
  localparam logic [9:0]        Y_LIM    = 10'(V_RES);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

  logic [10:0]       x_sum, x_end, x_end_m1;
  logic [9:0]        y_sum, y_end, y_end_m1;
  logic [ADDR_W-1:0] row_base_init;

  logic [9:0]        x0_q, cx_q, x_last_q;
  logic [8:0]        cy_q, y_last_q;
  logic [ADDR_W-1:0] row_base_q;

  // Bounds are summed one bit wider than the operands so x0+w never wraps
  // before the clip to the screen edge.
  assign x_sum    = {1'b0, x0} + {1'b0, w};
  assign y_sum    = {1'b0, y0} + {1'b0, h};
  assign x_end    = (x_sum > X_LIM) ? X_LIM : x_sum;
  assign y_end    = (y_sum > Y_LIM) ? Y_LIM : y_sum;
  assign x_end_m1 = x_end - 11'd1;
  assign y_end_m1 = y_end - 10'd1;

  assign empty = (w == 10'd0) || (h == 9'd0) ||
                 ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);

  // y0*640 as shifts (512 + 128); only evaluated once per command.
  assign row_base_init = ADDR_W'({y0, 9'd0}) + ADDR_W'({y0, 7'd0});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_display or posedge rst) begin
    if (rst) begin
      x0_q       <= '0;
      cx_q       <= '0;
      x_last_q   <= '0;
      cy_q       <= '0;
      y_last_q   <= '0;
      row_base_q <= '0;
    end else if (load) begin
      x0_q       <= x0;
      cx_q       <= x0;
      x_last_q   <= x_end_m1[9:0];
      cy_q       <= y0;
      y_last_q   <= y_end_m1[8:0];
      row_base_q <= row_base_init;
    end else if (step) begin
      if (cx_q == x_last_q) begin
        cx_q       <= x0_q;
        cy_q       <= cy_q + 9'd1;
        row_base_q <= row_base_q + ROW_STEP;
      end else begin
        cx_q <= cx_q + 10'd1;
      end
    end
  end

  assign addr = row_base_q + ADDR_W'(cx_q);
  assign last = (cx_q == x_last_q) && (cy_q == y_last_q);

endmodule

// File: rtl/fb_fill_scheduler.sv
// Rectangle-fill engine: accepts one fill command and issues single-pixel
// framebuffer writes only while the display is blanking.
module fb_fill_scheduler
  import screen_pkg::*;
(
  input  logic              clk_display,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [9:0]        req_x0,
  input  logic [8:0]        req_y0,
  input  logic [9:0]        req_w,
  input  logic [8:0]        req_h,
  input  color_t            req_color,
  input  logic              vid_blank,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output color_t            fb_wdata,
  output logic              busy,
  output logic              done
);

  fill_state_t state_q, state_d;
  color_t      color_q;
  logic        load, empty, last;

  fill_cursor u_cursor (
    .clk_display (clk_display),
    .rst         (rst),
    .load        (load),
    .step        (fb_we),
    .x0          (req_x0),
    .y0          (req_y0),
    .w           (req_w),
    .h           (req_h),
    .empty       (empty),
    .addr        (fb_addr),
    .last        (last)
  );

  always_ff @(posedge clk_display or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      color_q <= COLOR_BLACK;
    end else begin
      state_q <= state_d;
      if (req_valid && req_ready) color_q <= req_color;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    fb_we     = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (empty) begin
            state_d = DONE;
          end else begin
            state_d = FILL;
            load    = 1'b1;
          end
        end
      end
      FILL: begin
        // Writes stall while scanout owns the framebuffer.
        fb_we = vid_blank;
        if (vid_blank && last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fb_wdata = color_q;

endmodule
